pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//  Receive-side counterpart of the pwm generator: measures period and high time of an external PWM input.
//  Sits between an async PWM pin (RC receiver, sensor, looped-back pwm output) and control logic.
//  Publishes a {period, high_time} pair with a 1-cycle valid strobe per complete period.
//  Flags loss of signal / stuck input.
// PARAMETERS
//  CLK_FREQ      100000000                   clk frequency, Hz
//  MIN_PWM_FREQ  1000                        lowest accepted PWM frequency, Hz
//  MAX_CNT       CLK_FREQ/MIN_PWM_FREQ       timeout threshold, clk cycles
//  WL            $clog2(MAX_CNT+1)           width of counters and measurement outputs
//  FILTER_LEN    4                           glitch filter depth, cycles (used only with PWM_CAP_FILTER_EN)
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high reset
//  i_pwm          in   1   asynchronous PWM input
//  o_period       out  WL  last measured period, clk cycles (rise to rise)
//  o_high_time    out  WL  last measured high time, clk cycles (rise to fall)
//  o_valid        out  1   1-cycle strobe: o_period/o_high_time updated this cycle
//  o_timeout      out  1   level: no rising edge within MAX_CNT cycles; cleared on next valid
//  o_stuck_high   out  1   level at timeout: 1 = input stuck high, 0 = stuck low; meaningful only with o_timeout
// BEHAVIOUR
//  - Reset: all outputs 0, sync/filter flops 0, counters 0, state SYNC. Reset mid-measurement discards it.
//  - Input path: 2-flop synchronizer -> s (2-cycle latency). s_prev = s delayed 1 cycle.
//    rise = s & ~s_prev; fall = ~s & s_prev.
//  - FSM (one-hot or encoded, implementer's choice):
//    SYNC : wait for s==0 -> ARM. Prevents a partial first pulse after reset or timeout.
//    ARM  : on rise -> HIGH; period_cnt<=1, high_cnt<=1. No output.
//    HIGH : period_cnt++, high_cnt++ each cycle. On fall: high_lat<=high_cnt -> LOW.
//    LOW  : period_cnt++. On rise: o_period<=period_cnt, o_high_time<=high_lat, o_valid<=1,
//           o_timeout<=0; period_cnt<=1, high_cnt<=1 -> HIGH.
//  - Counting rule: rises N cycles apart give period N; rise and fall H cycles apart give high time H.
//    Looped-back pwm (PWM_MAX_CNT=P, duty D<P) reads period P+1, high D+1.
//  - The first valid occurs on the 2nd rise after ARM. o_valid is never high two cycles in a row.
//  - Timeout: in HIGH or LOW, if period_cnt==MAX_CNT and no rise this cycle:
//    o_timeout<=1, o_stuck_high<=s, -> SYNC.
//    o_period/o_high_time hold their last values. A rise in the same cycle as MAX_CNT is a valid edge.
//  - Counters never exceed MAX_CNT, so no wrap-around. Widths are fixed at WL with no truncation.
//  - Pulse widths below 1 cycle after sync/filter are invisible by design.
// CONFIGURATION
//  PWM_CAP_FILTER_EN defined:
//    s is replaced by filtered f. f changes only after FILTER_LEN consecutive identical synchronized samples.
//    Adds FILTER_LEN cycles of latency to both edges, so measured widths are unchanged.
//    Pulses/glitches shorter than FILTER_LEN are rejected. Filter counter resets to 0; f resets to 0.
//  PWM_CAP_FILTER_EN undefined:
//    no filter logic and FILTER_LEN is ignored. Every synchronized transition counts.
// TESTING
//  1. Reset release, i_pwm low, then period 5001 / high 2501 cycles -> first o_valid at 2nd rise;
//     o_period=5001, o_high_time=2501, one strobe per period thereafter.
//  2. Reset released while i_pwm high mid-pulse -> no valid until a full low-high-low-high sequence;
//     the first reported values are exact.
//  3. Duty step 2501->1001 high, period 5001 -> the period containing the change reports the new high
//     time 1001; no spurious strobes.
//  4. i_pwm held high after a rise, MAX_CNT=100000 -> o_timeout=1, o_stuck_high=1 exactly MAX_CNT cycles
//     after the last rise; then restore the signal -> o_timeout=0 at the next o_valid.
//  5. reset asserted for 1 cycle mid-HIGH -> outputs 0 next cycle, state SYNC, resumes per scenario 1.
//  6. With PWM_CAP_FILTER_EN, FILTER_LEN=4: 3-cycle glitch inside the low phase -> ignored, period unchanged;
//     a 4-cycle pulse is measured as high 4.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input and flags loss of signal.
// Optional glitch filter on the synchronized input is enabled by defining PWM_CAP_FILTER_EN.
module pwm_capture #(
  parameter int CLK_FREQ     = 100000000,
  parameter int MIN_PWM_FREQ = 1000,
  parameter int MAX_CNT      = CLK_FREQ / MIN_PWM_FREQ,
  parameter int WL           = $clog2(MAX_CNT + 1),
  parameter int FILTER_LEN   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_pwm,
  output logic [WL-1:0] o_period,
  output logic [WL-1:0] o_high_time,
  output logic          o_valid,
  output logic          o_timeout,
  output logic          o_stuck_high
);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  // Sync/filter flops reset to 0, so they do not reflect the pin until this many cycles
  // have passed; leaving SYNC earlier could mistake a pin that was high through reset for a rise.
  localparam int WARM = 3 + FILTER_LEN;
  localparam int WW   = $clog2(WARM + 1);
  localparam logic [WL-1:0] CNT_MAX = WL'(MAX_CNT);
  localparam logic [WL-1:0] CNT_ONE = WL'(1);

  logic          sync1_r;
  logic          sync2_r;
  logic          sig_s;
  logic          sig_prev_r;
  logic          rise_s;
  logic          fall_s;
  logic          timeout_s;
  logic          warm_done_s;
  logic [WW-1:0] warm_r;
  state_t        state_r;
  logic [WL-1:0] period_cnt_r;
  logic [WL-1:0] high_cnt_r;
  logic [WL-1:0] high_lat_r;

  // two-flop synchronizer for the asynchronous pin
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= i_pwm;
      sync2_r <= sync1_r;
    end
  end

`ifdef PWM_CAP_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] flt_cnt_r;
  logic          flt_r;

  // filtered level follows the synchronized input only after FILTER_LEN agreeing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      flt_cnt_r <= {FW{1'b0}};
      flt_r     <= 1'b0;
    end else if (sync2_r == flt_r) begin
      flt_cnt_r <= {FW{1'b0}};
    end else if (flt_cnt_r == FW'(FILTER_LEN - 1)) begin
      flt_cnt_r <= {FW{1'b0}};
      flt_r     <= sync2_r;
    end else begin
      flt_cnt_r <= flt_cnt_r + FW'(1);
    end
  end

  assign sig_s = flt_r;
`else
  assign sig_s = sync2_r;
`endif

  assign rise_s      = sig_s & ~sig_prev_r;
  assign fall_s      = ~sig_s & sig_prev_r;
  assign timeout_s   = (period_cnt_r == CNT_MAX) & ~rise_s;
  assign warm_done_s = (warm_r == WW'(WARM));

  // edge history and post-reset settle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_prev_r <= 1'b0;
      warm_r     <= {WW{1'b0}};
    end else begin
      sig_prev_r <= sig_s;
      if (!warm_done_s) begin
        warm_r <= warm_r + WW'(1);
      end else begin
        warm_r <= warm_r;
      end
    end
  end

  // measurement FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_SYNC;
      period_cnt_r <= {WL{1'b0}};
      high_cnt_r   <= {WL{1'b0}};
      high_lat_r   <= {WL{1'b0}};
      o_period     <= {WL{1'b0}};
      o_high_time  <= {WL{1'b0}};
      o_valid      <= 1'b0;
      o_timeout    <= 1'b0;
      o_stuck_high <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state_r)
        ST_SYNC: begin
          if (warm_done_s && !sig_s) begin
            state_r <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (rise_s) begin
            period_cnt_r <= CNT_ONE;
            high_cnt_r   <= CNT_ONE;
            state_r      <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (timeout_s) begin
            o_timeout    <= 1'b1;
            o_stuck_high <= sig_s;
            state_r      <= ST_SYNC;
          end else if (fall_s) begin
            high_lat_r   <= high_cnt_r;
            period_cnt_r <= period_cnt_r + CNT_ONE;
            state_r      <= ST_LOW;
          end else begin
            period_cnt_r <= period_cnt_r + CNT_ONE;
            high_cnt_r   <= high_cnt_r + CNT_ONE;
          end
        end
        ST_LOW: begin
          // a rise on the MAX_CNT cycle still closes the period
          if (rise_s) begin
            o_period     <= period_cnt_r;
            o_high_time  <= high_lat_r;
            o_valid      <= 1'b1;
            o_timeout    <= 1'b0;
            period_cnt_r <= CNT_ONE;
            high_cnt_r   <= CNT_ONE;
            state_r      <= ST_HIGH;
          end else if (timeout_s) begin
            o_timeout    <= 1'b1;
            o_stuck_high <= sig_s;
            state_r      <= ST_SYNC;
          end else begin
            period_cnt_r <= period_cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_SYNC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table-driven PWM periods checked through a scoreboard,
// plus hand-written reset, timeout and (optionally) filter sequences.
module tb_pwm_capture;

  localparam int TB_MAX = 10000;
  localparam int TB_WL  = $clog2(TB_MAX + 1);
`ifdef PWM_CAP_FILTER_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             i_pwm = 1'b0;
  logic [TB_WL-1:0] o_period;
  logic [TB_WL-1:0] o_high_time;
  logic             o_valid;
  logic             o_timeout;
  logic             o_stuck_high;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int per;
    int hi;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int hi;
    int lo;
    int exp_per;
    int exp_hi;
    bit meas;
  } vec_t;
  vec_t tbl[8];

  pwm_capture #(
    .CLK_FREQ    (5000000),
    .MIN_PWM_FREQ(500),
    .FILTER_LEN  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_pwm       (i_pwm),
    .o_period    (o_period),
    .o_high_time (o_high_time),
    .o_valid     (o_valid),
    .o_timeout   (o_timeout),
    .o_stuck_high(o_stuck_high)
  );

  always #5 clk = ~clk;

  initial begin
    #(900000 * 10);
    $display("FAIL watchdog: simulation did not finish, act=running req=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int hi, input int lo, input bit meas, input int eper, input int ehi);
    if (meas) sb.push_back('{per: eper, hi: ehi});
    i_pwm = 1'b1;
    tick(hi);
    i_pwm = 1'b0;
    tick(lo);
  endtask

  task automatic do_reset(input bit pin);
    i_pwm = pin;
    reset = 1'b1;
    sb.delete();
    tick(3);
    reset = 1'b0;
  endtask

  task automatic wait_to(input int bound, output int cyc);
    cyc = -1;
    for (int k = 1; k <= bound; k++) begin
      tick(1);
      if (o_timeout) begin
        cyc = k;
        break;
      end
    end
  endtask

  // scoreboard: every strobe must match the oldest expected period
  bit prev_v = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (o_valid) begin
        chk("valid_back_to_back", int'(prev_v), 0);
        chk("valid_expected", int'(sb.size() != 0), 1);
        chk("timeout_clr_on_valid", int'(o_timeout), 0);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("period", int'(o_period), e.per);
          chk("high_time", int'(o_high_time), e.hi);
        end
      end
      prev_v = o_valid;
    end
  end

  initial begin
    int cyc;

    tbl[0] = '{hi: 2501, lo: 2500, exp_per: 5001, exp_hi: 2501, meas: 1'b1};
    tbl[1] = '{hi: 1001, lo: 4000, exp_per: 5001, exp_hi: 1001, meas: 1'b1};
`ifdef PWM_CAP_FILTER_EN
    tbl[2] = '{hi: 4,    lo: 6,    exp_per: 10,   exp_hi: 4,    meas: 1'b1};
    tbl[3] = '{hi: 6,    lo: 4,    exp_per: 10,   exp_hi: 6,    meas: 1'b1};
`else
    tbl[2] = '{hi: 1,    lo: 9,    exp_per: 10,   exp_hi: 1,    meas: 1'b1};
    tbl[3] = '{hi: 9,    lo: 1,    exp_per: 10,   exp_hi: 9,    meas: 1'b1};
`endif
    tbl[4] = '{hi: 4000, lo: 6000, exp_per: 10000, exp_hi: 4000, meas: 1'b1};
    tbl[5] = '{hi: 37,   lo: 63,   exp_per: 100,  exp_hi: 37,   meas: 1'b1};
    tbl[6] = '{hi: 20,   lo: 30,   exp_per: 50,   exp_hi: 20,   meas: 1'b1};
    tbl[7] = '{hi: 50,   lo: 50,   exp_per: 0,    exp_hi: 0,    meas: 1'b0};

    // reset state
    do_reset(1'b0);
    chk("rst_period", int'(o_period), 0);
    chk("rst_high_time", int'(o_high_time), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_timeout", int'(o_timeout), 0);
    chk("rst_stuck_high", int'(o_stuck_high), 0);
    tick(10);

    // table: nominal, duty step, narrow pulses, period exactly MAX_CNT
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].hi, tbl[i].lo, tbl[i].meas, tbl[i].exp_per, tbl[i].exp_hi);
    end
    tick(10);
    chk("table_pending", sb.size(), 0);

    // reset released mid-pulse: partial pulse must not be measured
    do_reset(1'b1);
    tick(20);
    i_pwm = 1'b0;
    tick(30);
    drive(120, 180, 1'b1, 300, 120);
    drive(75, 25, 1'b1, 100, 75);
    drive(50, 50, 1'b0, 0, 0);
    tick(10);
    chk("midpulse_pending", sb.size(), 0);

    // stuck high, recovery, then stuck low
    do_reset(1'b0);
    tick(10);
    drive(200, 100, 1'b1, 300, 200);
    i_pwm = 1'b1;
    wait_to(TB_MAX + 50, cyc);
    chk("timeout_latency", cyc, TB_MAX + LAT);
    chk("stuck_high", int'(o_stuck_high), 1);
    chk("to_hold_period", int'(o_period), 300);
    chk("to_hold_high", int'(o_high_time), 200);
    i_pwm = 1'b0;
    tick(50);
    chk("timeout_level", int'(o_timeout), 1);
    drive(180, 120, 1'b1, 300, 180);
    drive(150, 150, 1'b0, 0, 0);
    chk("timeout_cleared", int'(o_timeout), 0);
    chk("recover_pending", sb.size(), 0);
    wait_to(TB_MAX + 100, cyc);
    chk("timeout_low_seen", int'(o_timeout), 1);
    chk("stuck_low", int'(o_stuck_high), 0);
    chk("to_low_hold_period", int'(o_period), 300);
    chk("to_low_hold_high", int'(o_high_time), 180);

    // one-cycle reset in the middle of a high phase
    do_reset(1'b0);
    tick(10);
    drive(100, 100, 1'b1, 200, 100);
    i_pwm = 1'b1;
    tick(40);
    reset = 1'b1;
    sb.delete();
    tick(1);
    reset = 1'b0;
    chk("mid_rst_period", int'(o_period), 0);
    chk("mid_rst_high_time", int'(o_high_time), 0);
    chk("mid_rst_valid", int'(o_valid), 0);
    chk("mid_rst_timeout", int'(o_timeout), 0);
    tick(60);
    i_pwm = 1'b0;
    tick(100);
    drive(100, 100, 1'b1, 200, 100);
    drive(70, 130, 1'b1, 200, 70);
    drive(50, 50, 1'b0, 0, 0);
    tick(10);
    chk("mid_rst_pending", sb.size(), 0);

`ifdef PWM_CAP_FILTER_EN
    // glitch rejection and minimum accepted pulse
    do_reset(1'b0);
    tick(20);
    sb.push_back('{per: 250, hi: 100});
    i_pwm = 1'b1;
    tick(100);
    i_pwm = 1'b0;
    tick(50);
    i_pwm = 1'b1;
    tick(3);
    i_pwm = 1'b0;
    tick(97);
    drive(4, 96, 1'b1, 100, 4);
    drive(50, 50, 1'b0, 0, 0);
    tick(10);
    chk("filter_pending", sb.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
